prog_counter: RTL and testbench

Program counter and fetch sequencer for the 9-bit CPU. Holds the 12-bit instruction address, advances it each cycle, and applies signed relative branch offsets produced by the branch target lookup (3-bit selector → 12-bit offset) directly upstream. It also sequences program start, stall and halt for the instruction ROM and the testbench.

---
 rtl/pc_pkg.sv | 16 +
 rtl/pc_ret_stack.sv | 48 ++++
 rtl/prog_counter.sv | 138 +++++++++++++
 tb/tb_prog_counter.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared types and constants for the 9-bit CPU program counter.
// The optional return stack is enabled with the PC_CALL_STACK_EN macro.
package pc_pkg;

  localparam int unsigned PC_W           = 12;
  localparam int unsigned PC_STACK_DEPTH = 4;

  typedef logic [PC_W-1:0] pc_t;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t RUN  = 2'd1;
  localparam state_t HALT = 2'd2;

endpackage

// File: rtl/pc_ret_stack.sv
// Return-address LIFO for relative calls; built only when PC_CALL_STACK_EN is defined.
// A push when full or a pop when empty is ignored; the caller flags the error.
module pc_ret_stack
  import pc_pkg::*;
#(
  parameter int unsigned W     = PC_W,
  parameter int unsigned DEPTH = PC_STACK_DEPTH
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [CW-1:0] r_count;
  logic [AW-1:0] w_wr_idx;
  logic [AW-1:0] w_rd_idx;
  logic [CW-1:0] w_count_m1;

  assign w_count_m1 = r_count - CW'(1);
  assign w_wr_idx   = r_count[AW-1:0];
  assign w_rd_idx   = w_count_m1[AW-1:0];

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_data  = r_mem[w_rd_idx];

  // Storage itself is not reset; only the occupancy count matters.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_push && !o_full) begin
      r_mem[w_wr_idx] <= i_data;
      r_count         <= r_count + CW'(1);
    end else if (i_pop && !o_empty) begin
      r_count <= w_count_m1;
    end
  end

endmodule

// File: rtl/prog_counter.sv
// Program counter and fetch sequencer (IDLE/RUN/HALT) for the 9-bit CPU.
// Define PC_CALL_STACK_EN to add relative call/return through a return stack.
module prog_counter
  import pc_pkg::*;
#(
  parameter int unsigned D           = PC_W,
  parameter int unsigned STACK_DEPTH = PC_STACK_DEPTH
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         stall,
  input  logic         branch_en,
  input  logic [D-1:0] target,
  input  logic         halt_req,
  input  logic         call_en,
  input  logic         ret_en,
  output logic [D-1:0] prog_ctr,
  output logic         running,
  output logic         done,
  output logic         stk_err
);

  state_t       r_state, w_state_d;
  logic [D-1:0] r_pc, w_pc_d;
  logic [D-1:0] w_pc_inc, w_pc_br;
  logic         r_done, w_done_d;

  // Offset is already D bits wide, so modular addition is the sign extension.
  assign w_pc_inc = r_pc + D'(1);
  assign w_pc_br  = r_pc + target;

`ifdef PC_CALL_STACK_EN
  logic         w_push, w_pop, w_err_set;
  logic         w_full, w_empty;
  logic [D-1:0] w_top;
  logic         r_stk_err;
`endif

  always_comb begin
    w_state_d = r_state;
    w_pc_d    = r_pc;
    w_done_d  = 1'b0;
`ifdef PC_CALL_STACK_EN
    w_push    = 1'b0;
    w_pop     = 1'b0;
    w_err_set = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        w_pc_d = '0;
        if (start) w_state_d = RUN;
      end
      RUN: begin
        if (halt_req) begin
          w_state_d = HALT;
          w_done_d  = 1'b1;
        end else if (stall) begin
          w_pc_d = r_pc;
        end
`ifdef PC_CALL_STACK_EN
        else if (ret_en) begin
          if (w_empty) begin
            w_err_set = 1'b1;
            w_pc_d    = w_pc_inc;
          end else begin
            w_pop  = 1'b1;
            w_pc_d = w_top;
          end
        end else if (call_en) begin
          w_pc_d = w_pc_br;
          if (w_full) w_err_set = 1'b1;
          else        w_push    = 1'b1;
        end
`endif
        else if (branch_en) begin
          w_pc_d = w_pc_br;
        end else begin
          w_pc_d = w_pc_inc;
        end
      end
      HALT: begin
        if (!start) begin
          w_state_d = IDLE;
          w_pc_d    = '0;
        end
      end
      default: begin
        w_state_d = IDLE;
        w_pc_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_pc    <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_pc    <= w_pc_d;
      r_done  <= w_done_d;
    end
  end

  assign prog_ctr = r_pc;
  assign running  = (r_state == RUN);
  assign done     = r_done;

`ifdef PC_CALL_STACK_EN
  pc_ret_stack #(
    .W     (D),
    .DEPTH (STACK_DEPTH)
  ) u_ret_stack (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_pc_inc),
    .o_data  (w_top),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk) begin
    if (reset)          r_stk_err <= 1'b0;
    else if (w_err_set) r_stk_err <= 1'b1;
  end

  assign stk_err = r_stk_err;
`else
  logic w_unused;
  assign w_unused = ^{call_en, ret_en, STACK_DEPTH[0]};
  assign stk_err  = 1'b0;
`endif

endmodule

// File: tb/tb_prog_counter.sv
// Scoreboard bench for prog_counter; expectations adapt to PC_CALL_STACK_EN.
module tb_prog_counter;

  localparam int unsigned D = 12;
`ifdef PC_CALL_STACK_EN
  localparam bit CS = 1'b1;
`else
  localparam bit CS = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset, start, stall, branch_en, halt_req, call_en, ret_en;
  logic [D-1:0] target;
  logic [D-1:0] prog_ctr;
  logic         running, done, stk_err;

  always #5 clk = ~clk;

  prog_counter #(
    .D           (D),
    .STACK_DEPTH (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .stall     (stall),
    .branch_en (branch_en),
    .target    (target),
    .halt_req  (halt_req),
    .call_en   (call_en),
    .ret_en    (ret_en),
    .prog_ctr  (prog_ctr),
    .running   (running),
    .done      (done),
    .stk_err   (stk_err)
  );

  typedef struct {
    int unsigned  cyc;
    logic [D-1:0] pc;
    logic         run;
    logic         dn;
    logic         err;
    string        name;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned cyc    = 0;
  int unsigned n_cmp  = 0;
  int unsigned n_bad  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every cycle the DUT presents a new PC; compare entries due now.
  always @(negedge clk) begin : monitor
    exp_t e;
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      e = sb_q.pop_front();
      n_cmp++;
      if (e.cyc != cyc || prog_ctr !== e.pc || running !== e.run ||
          done !== e.dn || stk_err !== e.err) begin
        n_bad++;
        $display("FAIL %s: got pc=%0d running=%b done=%b stk_err=%b, want pc=%0d running=%b done=%b stk_err=%b (cyc %0d/%0d)",
                 e.name, prog_ctr, running, done, stk_err, e.pc, e.run, e.dn, e.err, cyc, e.cyc);
      end
    end
  end

  // Drive one cycle of inputs and queue the outputs expected after the next edge.
  task automatic step(input string name, input logic rst, input logic st, input logic stl,
                      input logic br, input logic hlt, input logic cl, input logic rt,
                      input logic [D-1:0] tgt, input logic [D-1:0] epc, input logic erun,
                      input logic edn, input logic eerr);
    exp_t e;
    @(posedge clk);
    #1;
    reset     = rst;
    start     = st;
    stall     = stl;
    branch_en = br;
    halt_req  = hlt;
    call_en   = cl;
    ret_en    = rt;
    target    = tgt;
    e.cyc  = cyc + 1;
    e.pc   = epc;
    e.run  = erun;
    e.dn   = edn;
    e.err  = eerr;
    e.name = name;
    sb_q.push_back(e);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stall = 1'b0; branch_en = 1'b0;
    halt_req = 1'b0; call_en = 1'b0; ret_en = 1'b0; target = '0;

    //    name          rst   st    stl   br    hlt   cl    rt    tgt       pc    run   dn    err
    step("reset",      1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'd0,    12'd0, 1'b0, 1'b0, 1'b0);
    step("idle",       1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'd0,    12'd0, 1'b0, 1'b0, 1'b0);
    step("start",      1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'd0,    12'd0, 1'b1, 1'b0, 1'b0);
    step("inc1",       1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'd0,    12'd1, 1'b1, 1'b0, 1'b0);
    step("inc2",       1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'd0,    12'd2, 1'b1, 1'b0, 1'b0);
    step("br_p10",     1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'd10,   12'd12, 1'b1, 1'b0, 1'b0);
    step("inc13",      1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'd0,    12'd13, 1'b1, 1'b0, 1'b0);
    step("mid_reset",  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'd0,    12'd0, 1'b0, 1'b0, 1'b0);
    step("restart",    1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'd0,    12'd0, 1'b1, 1'b0, 1'b0);
    step("br_to31",    1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'd31,   12'd31, 1'b1, 1'b0, 1'b0);
    step("br_m41",     1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'hFD7,  12'd4086, 1'b1, 1'b0, 1'b0);
    step("br_to4095",  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'd9,    12'd4095, 1'b1, 1'b0, 1'b0);
    step("wrap",       1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'd0,    12'd0, 1'b1, 1'b0, 1'b0);
    step("inc_w1",     1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'd0,    12'd1, 1'b1, 1'b0, 1'b0);
    step("br_to7",     1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'd6,    12'd7, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step("stall_br", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 12'd50,   12'd7, 1'b1, 1'b0, 1'b0);
    end
    step("unstall",    1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'd0,    12'd8, 1'b1, 1'b0, 1'b0);
    step("br_to20",    1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'd12,   12'd20, 1'b1, 1'b0, 1'b0);
    step("halt_br",    1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 12'd5,    12'd20, 1'b0, 1'b1, 1'b0);
    step("halt_hold1", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'd0,    12'd20, 1'b0, 1'b0, 1'b0);
    step("halt_hold2", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'd3,    12'd20, 1'b0, 1'b0, 1'b0);
    step("halt_exit",  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'd0,    12'd0, 1'b0, 1'b0, 1'b0);
    step("idle2",      1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'd9,    12'd0, 1'b0, 1'b0, 1'b0);
    step("go2",        1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'd0,    12'd0, 1'b1, 1'b0, 1'b0);
    step("br_to5",     1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'd5,    12'd5, 1'b1, 1'b0, 1'b0);
    step("call_p100",  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 12'd100,
         CS ? 12'd105 : 12'd6, 1'b1, 1'b0, 1'b0);
    step("ret",        1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 12'd0,
         CS ? 12'd6 : 12'd7, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step("call_nest", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 12'd1,
           CS ? 12'(7 + i) : 12'(8 + i), 1'b1, 1'b0, 1'b0);
    end
    step("call_full",  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 12'd1,
         CS ? 12'd11 : 12'd12, 1'b1, 1'b0, CS);
    step("rst_err",    1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'd0,    12'd0, 1'b0, 1'b0, 1'b0);
    step("go3",        1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'd0,    12'd0, 1'b1, 1'b0, 1'b0);
    step("br_to40",    1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'd40,   12'd40, 1'b1, 1'b0, 1'b0);
    step("ret_empty",  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 12'd0,    12'd41, 1'b1, 1'b0, CS);
    step("stall_ret",  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 12'd0,    12'd41, 1'b1, 1'b0, CS);
    step("err_sticky", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'd0,    12'd42, 1'b1, 1'b0, CS);

    // Bounded drain of the scoreboard.
    repeat (4) @(negedge clk);
    if (sb_q.size() != 0) begin
      $display("FAIL drain: got %0d pending expectations, want 0", sb_q.size());
      n_bad += sb_q.size();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
